cpu4_ctrl_fsm: RTL
==================

// Module: cpu4_ctrl_fsm
// PURPOSE
//  Multi-cycle control unit for the 4-bit processor: fetches 8-bit instructions, decodes them,
//  and sequences the shared 4-bit ALU (XOR/AND/OR/ADD/SUB/NOT/PASS).
//  Owns PC and Z/C flags; drives ALU op select, immediate and accumulator write enable.
//  Sits between instruction memory and the ALU/accumulator datapath.
// PARAMETERS
//  PC_W     4   program counter / imem address width (16-word program space)
//  RST_PC   0   PC value loaded on reset
// PORTS
//  clk         in   1     system clock, rising edge
//  rst_n       in   1     synchronous active-low reset
//  imem_req    out  1     fetch request; held high until imem_ack
//  imem_addr   out  PC_W  fetch address (= PC)
//  imem_ack    in   1     fetch done; imem_data valid this cycle (same-cycle ack allowed)
//  imem_data   in   8     instruction: [7:4] opcode, [3:0] imm/target
//  alu_op      out  3     0 PASS_B,1 ADD,2 SUB,3 AND,4 OR,5 XOR,6 NOT_A
//  alu_imm     out  4     ALU B operand (instruction imm)
//  alu_zero    in   1     ALU result==0, valid in EXEC
//  alu_carry   in   1     ALU carry/borrow-out, valid in EXEC
//  acc_we      out  1     accumulator write strobe, 1-cycle pulse in EXEC
//  flag_z      out  1     registered zero flag
//  flag_c      out  1     registered carry flag
//  halted      out  1     high while in HALT
//  illegal     out  1     1-cycle pulse on undefined opcode (executed as NOP)
//  step        in   1     single-step pulse (present only with CTRL_SINGLE_STEP_EN)
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=FETCH, PC=RST_PC, flags=0, IR=0x00; all outputs 0.
//   Overrides any state incl. pending fetch; imem_req re-asserts the cycle after release.
//  States: FETCH -> DECODE -> EXEC -> FETCH; HLT goes EXEC -> HALT.
//  FETCH: imem_req=1, imem_addr=PC. On imem_ack: IR<=imem_data, PC<=PC+1 (mod 2^PC_W
//   wraps to 0), goto DECODE. imem_ack with imem_req=0 ignored.
//  DECODE: 1 cycle; registers alu_op/alu_imm/control from IR; no strobes.
//  EXEC: 1 cycle. ALU ops: acc_we=1; flag_z<=alu_zero, flag_c<=alu_carry at cycle end.
//  Opcodes: 0 NOP; 1 LDI(PASS_B, updates Z, C<=0); 2 ADD; 3 SUB; 4 AND; 5 OR; 6 XOR;
//   7 NOT; 8 JMP imm; 9 JZ imm; A JC imm; F HLT; B-E illegal (pulse illegal, act as NOP).
//  AND/OR/XOR/NOT update Z only, C preserved. Jumps: PC<=imm (zero-extended) if
//   condition true on registered flags; no flag change; no acc_we.
//  Latency: min 3 cycles/instr (ack in first FETCH cycle); +1 per imem wait cycle.
//  HALT: imem_req=0, halted=1, no strobes; exit only by reset.
//  alu_op/alu_imm stable DECODE..EXEC; 0 in FETCH/HALT.
// CONFIGURATION
//  CTRL_SINGLE_STEP_EN defined: step port exists; FETCH does not assert imem_req until
//   a step pulse seen (step sampled high while in FETCH w/o pending req); one instr/pulse;
//   extra pulses while not in FETCH ignored. Once raised, imem_req holds until ack.
//  Undefined: no step port; FETCH asserts imem_req immediately (free-running).
// STRUCTURE
//  cpu4_defs.vh (shared include): opcode localparams, ALU op codes, state encoding,
//   instruction field positions.
//  One sub-module: cpu4_decoder -- combinational IR -> {alu_op, acc_we_en, z_en, c_en,
//   c_clr, jmp, jz, jc, hlt, illegal}. FSM, PC, IR, flags stay in cpu4_ctrl_fsm.
// TESTING
//  1 Reset then imem ack same-cycle with 0x15 (LDI 5): imem_addr=0, acc_we pulses 3rd cycle,
//    alu_op=0, alu_imm=5, next fetch addr=1.
//  2 ADD 0xB with alu_carry=1, alu_zero=1 in EXEC -> flag_c=1, flag_z=1; then JC 0x9
//    -> next imem_addr=9; JZ with flag_z=0 -> next addr=PC+1.
//  3 XOR 0x3 with flag_c=1 and alu_zero=0 -> flag_c stays 1, flag_z=0; imem_ack delayed
//    2 cycles -> imem_req held, instr takes 5 cycles.
//  4 PC=15 fetch NOP -> next addr 0; opcode 0xC -> illegal pulse 1 cycle, no acc_we.
//  5 HLT (0xF0) -> halted=1, imem_req=0 for 20 cycles; rst_n=0 one cycle mid-fetch
//    (imem_req high) -> next cycle req=0, cycle after req=1, addr=0, flags=0.
//  6 CTRL_SINGLE_STEP_EN: no imem_req for 10 cycles w/o step; one step -> exactly one
//    instr executed, back to FETCH idle.

Source files
------------

// File: rtl/cpu4_ctrl_fsm_pkg.sv
// Shared definitions for the 4-bit CPU control unit: opcodes, ALU op codes,
// FSM state encoding, instruction field helpers and the decoder output bundle.
package cpu4_ctrl_fsm_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDI = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_AND = 4'h4;
    localparam logic [3:0] OP_OR  = 4'h5;
    localparam logic [3:0] OP_XOR = 4'h6;
    localparam logic [3:0] OP_NOT = 4'h7;
    localparam logic [3:0] OP_JMP = 4'h8;
    localparam logic [3:0] OP_JZ  = 4'h9;
    localparam logic [3:0] OP_JC  = 4'hA;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [2:0] ALU_PASS_B = 3'd0;
    localparam logic [2:0] ALU_ADD    = 3'd1;
    localparam logic [2:0] ALU_SUB    = 3'd2;
    localparam logic [2:0] ALU_AND    = 3'd3;
    localparam logic [2:0] ALU_OR     = 3'd4;
    localparam logic [2:0] ALU_XOR    = 3'd5;
    localparam logic [2:0] ALU_NOT_A  = 3'd6;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2,
        ST_HALT   = 2'd3
    } state_e;

    typedef struct packed {
        logic [2:0] alu_op;
        logic       acc_we_en;
        logic       z_en;
        logic       c_en;
        logic       c_clr;
        logic       jmp;
        logic       jz;
        logic       jc;
        logic       hlt;
        logic       illegal;
    } dec_s;

    function automatic logic [3:0] instr_opcode(input logic [7:0] instr);
        return instr[7:4];
    endfunction

    function automatic logic [3:0] instr_imm(input logic [7:0] instr);
        return instr[3:0];
    endfunction

endpackage

// File: rtl/cpu4_ctrl_fsm_decoder.sv
// Combinational opcode decoder: maps an opcode to ALU select and control enables.
module cpu4_ctrl_fsm_decoder
    import cpu4_ctrl_fsm_pkg::*;
(
    input  logic [3:0] opcode,
    output dec_s       dec
);

    // Opcode to control bundle; unlisted opcodes are illegal and behave as NOP
    always_comb begin
        dec = '0;
        case (opcode)
            OP_NOP: dec.alu_op = ALU_PASS_B;
            OP_LDI: begin dec.alu_op = ALU_PASS_B; dec.acc_we_en = 1'b1; dec.z_en = 1'b1; dec.c_clr = 1'b1; end
            OP_ADD: begin dec.alu_op = ALU_ADD;    dec.acc_we_en = 1'b1; dec.z_en = 1'b1; dec.c_en  = 1'b1; end
            OP_SUB: begin dec.alu_op = ALU_SUB;    dec.acc_we_en = 1'b1; dec.z_en = 1'b1; dec.c_en  = 1'b1; end
            OP_AND: begin dec.alu_op = ALU_AND;    dec.acc_we_en = 1'b1; dec.z_en = 1'b1; end
            OP_OR:  begin dec.alu_op = ALU_OR;     dec.acc_we_en = 1'b1; dec.z_en = 1'b1; end
            OP_XOR: begin dec.alu_op = ALU_XOR;    dec.acc_we_en = 1'b1; dec.z_en = 1'b1; end
            OP_NOT: begin dec.alu_op = ALU_NOT_A;  dec.acc_we_en = 1'b1; dec.z_en = 1'b1; end
            OP_JMP: dec.jmp = 1'b1;
            OP_JZ:  dec.jz  = 1'b1;
            OP_JC:  dec.jc  = 1'b1;
            OP_HLT: dec.hlt = 1'b1;
            default: dec.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/cpu4_ctrl_fsm.sv
// Multi-cycle FETCH/DECODE/EXEC control unit for the 4-bit CPU; owns PC, IR and Z/C flags.
// Optional feature macro: CTRL_SINGLE_STEP_EN adds the step input (one instruction per pulse).
module cpu4_ctrl_fsm
    import cpu4_ctrl_fsm_pkg::*;
#(
    parameter int              PC_W   = 4,
    parameter logic [PC_W-1:0] RST_PC = {PC_W{1'b0}}
) (
    input  logic            clk,
    input  logic            rst_n,
`ifdef CTRL_SINGLE_STEP_EN
    input  logic            step,
`endif
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [7:0]      imem_data,
    output logic [2:0]      alu_op,
    output logic [3:0]      alu_imm,
    input  logic            alu_zero,
    input  logic            alu_carry,
    output logic            acc_we,
    output logic            flag_z,
    output logic            flag_c,
    output logic            halted,
    output logic            illegal
);

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [7:0]      ir_q, ir_d;
    logic            fz_q, fz_d, fc_q, fc_d;
    logic            req_q, req_d;
    logic [2:0]      op_q, op_d;
    logic [3:0]      imm_q, imm_d;
    logic            we_q, we_d, ill_q, ill_d, halt_q, halt_d;
    logic [3:0]      dec_opc_s;
    dec_s            dec_s_w;
    logic            fetch_done_s;

    // While fetching, decode the incoming word so alu_op is already valid in DECODE
    assign dec_opc_s    = (state_q == ST_FETCH) ? instr_opcode(imem_data) : instr_opcode(ir_q);
    assign fetch_done_s = req_q & imem_ack;

    cpu4_ctrl_fsm_decoder u_dec (
        .opcode (dec_opc_s),
        .dec    (dec_s_w)
    );

    // Next-state, datapath-register and output computation
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        fz_d    = fz_q;
        fc_d    = fc_q;
        req_d   = 1'b0;
        op_d    = op_q;
        imm_d   = imm_q;
        we_d    = 1'b0;
        ill_d   = 1'b0;
        halt_d  = 1'b0;
        case (state_q)
            ST_FETCH: begin
                op_d  = ALU_PASS_B;
                imm_d = 4'h0;
                if (fetch_done_s) begin
                    ir_d    = imem_data;
                    pc_d    = pc_q + PC_W'(1);
                    op_d    = dec_s_w.alu_op;
                    imm_d   = instr_imm(imem_data);
                    state_d = ST_DECODE;
                end else begin
`ifdef CTRL_SINGLE_STEP_EN
                    req_d = req_q | step;
`else
                    req_d = 1'b1;
`endif
                end
            end
            ST_DECODE: begin
                we_d    = dec_s_w.acc_we_en;
                ill_d   = dec_s_w.illegal;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (dec_s_w.z_en) fz_d = alu_zero;
                else              fz_d = fz_q;
                if (dec_s_w.c_en)       fc_d = alu_carry;
                else if (dec_s_w.c_clr) fc_d = 1'b0;
                else                    fc_d = fc_q;
                // Jump conditions look at the flags as they stood before this instruction
                if (dec_s_w.jmp || (dec_s_w.jz && fz_q) || (dec_s_w.jc && fc_q)) pc_d = PC_W'(instr_imm(ir_q));
                else                                                            pc_d = pc_q;
                op_d  = ALU_PASS_B;
                imm_d = 4'h0;
                if (dec_s_w.hlt) begin
                    state_d = ST_HALT;
                    halt_d  = 1'b1;
                end else begin
                    state_d = ST_FETCH;
`ifdef CTRL_SINGLE_STEP_EN
                    req_d = 1'b0;
`else
                    req_d = 1'b1;
`endif
                end
            end
            ST_HALT: begin
                op_d   = ALU_PASS_B;
                imm_d  = 4'h0;
                halt_d = 1'b1;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
            pc_q    <= RST_PC;
            ir_q    <= 8'h00;
            fz_q    <= 1'b0;
            fc_q    <= 1'b0;
            req_q   <= 1'b0;
            op_q    <= 3'd0;
            imm_q   <= 4'h0;
            we_q    <= 1'b0;
            ill_q   <= 1'b0;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            fz_q    <= fz_d;
            fc_q    <= fc_d;
            req_q   <= req_d;
            op_q    <= op_d;
            imm_q   <= imm_d;
            we_q    <= we_d;
            ill_q   <= ill_d;
            halt_q  <= halt_d;
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = pc_q;
    assign alu_op    = op_q;
    assign alu_imm   = imm_q;
    assign acc_we    = we_q;
    assign flag_z    = fz_q;
    assign flag_c    = fc_q;
    assign halted    = halt_q;
    assign illegal   = ill_q;

endmodule
